// File: rtl/jtag_host.sv
// JTAG initiator: runs TAP reset, IR scans and DR scans from a command/response
// interface, generating TCK/TMS/TDI from clk and always parking the TAP in Run-Test/Idle.
module jtag_host #(
    parameter int DIV      = 4,
    parameter int IR_W     = 3,
    parameter int DR_MAX_W = 32,
    parameter int LEN_W    = $clog2(DR_MAX_W + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_v_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_type_i,
    input  logic [LEN_W-1:0]    cmd_len_i,
    input  logic [DR_MAX_W-1:0] cmd_data_i,
    output logic                rsp_v_o,
    input  logic                rsp_ready_i,
    output logic [DR_MAX_W-1:0] rsp_data_o,
    output logic                rsp_err_o,
    output logic                tck_o,
    output logic                tms_o,
    output logic                tdi_o,
    input  logic                tdo_i
);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_IR    = 2'b01;
    localparam logic [1:0] CMD_DR    = 2'b10;

    typedef enum logic [2:0] {INIT_RST, IDLE, PRE, SHIFT, POST, RSP} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [5:0]          seq_q, seq_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d, len_q, len_d;
    logic [DR_MAX_W-1:0] sh_q, sh_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
    logic [1:0]          type_q, type_d;
    logic                ready_q, ready_d, rsp_v_q, rsp_v_d, rsp_err_q, rsp_err_d;
    logic                active, half_end, rise, fall, bad_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT_RST;
            div_q      <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            seq_q      <= 6'b011111;
            cnt_q      <= LEN_W'(6);
            len_q      <= '0;
            sh_q       <= '0;
            cap_q      <= '0;
            type_q     <= CMD_RESET;
            ready_q    <= 1'b0;
            rsp_v_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sh_q       <= sh_d;
            cap_q      <= cap_d;
            type_q     <= type_d;
            ready_q    <= ready_d;
            rsp_v_q    <= rsp_v_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // rise/fall mark the last clk of the low and high TCK phases respectively.
    always_comb begin
        active   = (state_q == INIT_RST) || (state_q == PRE) || (state_q == SHIFT) || (state_q == POST);
        half_end = active && (div_q == DIV_W'(DIV - 1));
        rise     = half_end && !tck_q;
        fall     = half_end && tck_q;
        bad_cmd  = (cmd_type_i == 2'b11) ||
                   ((cmd_type_i == CMD_DR) && ((cmd_len_i == '0) || (cmd_len_i > LEN_W'(DR_MAX_W))));
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sh_d       = sh_q;
        cap_d      = cap_q;
        type_d     = type_q;
        ready_d    = ready_q;
        rsp_v_d    = rsp_v_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        if (active) begin
            div_d = half_end ? '0 : div_q + 1'b1;
            if (half_end) tck_d = ~tck_q;
        end

        case (state_q)
            INIT_RST: begin
                if (fall) begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end else begin
                        seq_d = seq_q >> 1;
                        cnt_d = cnt_q - LEN_W'(1);
                        tms_d = seq_q[1];
                    end
                end
            end
            IDLE: begin
                if (cmd_v_i && ready_q) begin
                    ready_d = 1'b0;
                    type_d  = cmd_type_i;
                    sh_d    = cmd_data_i;
                    cap_d   = '0;
                    div_d   = '0;
                    tck_d   = 1'b0;
                    if (bad_cmd) begin
                        state_d    = RSP;
                        rsp_v_d    = 1'b1;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        state_d = PRE;
                        tms_d   = 1'b1;
                        // TMS patterns are stored LSB-first; the first bit is driven now.
                        if (cmd_type_i == CMD_RESET) begin
                            seq_d = 6'b011111;
                            cnt_d = LEN_W'(6);
                        end else if (cmd_type_i == CMD_IR) begin
                            seq_d = 6'b000011;
                            cnt_d = LEN_W'(4);
                            len_d = LEN_W'(IR_W);
                        end else begin
                            seq_d = 6'b000001;
                            cnt_d = LEN_W'(3);
                            len_d = cmd_len_i;
                        end
                    end
                end
            end
            PRE: begin
                if (fall) begin
                    if (cnt_q != LEN_W'(1)) begin
                        seq_d = seq_q >> 1;
                        cnt_d = cnt_q - LEN_W'(1);
                        tms_d = seq_q[1];
                    end else if (type_q == CMD_RESET) begin
                        state_d    = RSP;
                        rsp_v_d    = 1'b1;
                        rsp_err_d  = 1'b0;
                        rsp_data_d = '0;
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = len_q;
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = sh_q[0];
                    end
                end
            end
            SHIFT: begin
                if (rise) cap_d = {tdo_i, cap_q[DR_MAX_W-1:1]};
                if (fall) begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = POST;
                        seq_d   = 6'b000001;
                        cnt_d   = LEN_W'(2);
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end else begin
                        sh_d  = sh_q >> 1;
                        tdi_d = sh_q[1];
                        cnt_d = cnt_q - LEN_W'(1);
                        tms_d = (cnt_q == LEN_W'(2));
                    end
                end
            end
            POST: begin
                if (fall) begin
                    if (cnt_q == LEN_W'(1)) begin
                        // Captured bits enter at the top; right-align them to bit 0.
                        state_d    = RSP;
                        rsp_v_d    = 1'b1;
                        rsp_err_d  = 1'b0;
                        rsp_data_d = cap_q >> (LEN_W'(DR_MAX_W) - len_q);
                    end else begin
                        seq_d = seq_q >> 1;
                        cnt_d = cnt_q - LEN_W'(1);
                        tms_d = seq_q[1];
                    end
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_v_d = 1'b0;
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = INIT_RST;
        endcase
    end

    assign cmd_ready_o = ready_q;
    assign rsp_v_o     = rsp_v_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host driving a behavioural TAP (IR_W=3, IDCODE 0x1BEEF0D7,
// IR capture 3'b001, any IR other than IDCODE selects a 1-bit bypass register).
module tb_jtag_host;
    localparam int DIV      = 2;
    localparam int IR_W     = 3;
    localparam int DR_MAX_W = 32;
    localparam int LEN_W    = 6;
    localparam logic [31:0] IDCODE    = 32'h1BEEF0D7;
    localparam logic [2:0]  IDCODE_OP = 3'b001;
    localparam int LIMIT = 2000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_v = 1'b0;
    logic              rsp_ready = 1'b0;
    logic [1:0]        cmd_type = 2'b00;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [31:0]       cmd_data = '0;
    logic              tdo = 1'b0;
    logic              cmd_ready, rsp_v, rsp_err, tck, tms, tdi;
    logic [31:0]       rsp_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jtag_host #(.DIV(DIV), .IR_W(IR_W), .DR_MAX_W(DR_MAX_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_type_i(cmd_type),
        .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
        .rsp_v_o(rsp_v), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
    );

    // Behavioural TAP, with a log of TMS/TDI/state at every TCK rising edge.
    typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                              SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_t;
    tap_t        tap_st = TLR;
    logic [2:0]  ir = IDCODE_OP;
    logic [2:0]  ir_sh = 3'b000;
    logic [31:0] dr_sh = 32'h0;
    int          tck_count = 0;
    logic        log_tms [1024];
    logic        log_tdi [1024];
    tap_t        log_st  [1024];

    always @(posedge tck) begin
        if (tck_count < 1024) begin
            log_tms[tck_count] = tms;
            log_tdi[tck_count] = tdi;
            log_st[tck_count]  = tap_st;
        end
        tck_count = tck_count + 1;
        case (tap_st)
            TLR:    ir = IDCODE_OP;
            CAP_DR: dr_sh = (ir == IDCODE_OP) ? IDCODE : 32'h0;
            SH_DR:  dr_sh = (ir == IDCODE_OP) ? {tdi, dr_sh[31:1]} : {31'h0, tdi};
            CAP_IR: ir_sh = 3'b001;
            SH_IR:  ir_sh = {tdi, ir_sh[2:1]};
            UPD_IR: ir = ir_sh;
            default: ;
        endcase
        case (tap_st)
            TLR:    tap_st = tms ? TLR    : RTI;
            RTI:    tap_st = tms ? SEL_DR : RTI;
            SEL_DR: tap_st = tms ? SEL_IR : CAP_DR;
            CAP_DR: tap_st = tms ? EX1_DR : SH_DR;
            SH_DR:  tap_st = tms ? EX1_DR : SH_DR;
            EX1_DR: tap_st = tms ? UPD_DR : PA_DR;
            PA_DR:  tap_st = tms ? EX2_DR : PA_DR;
            EX2_DR: tap_st = tms ? UPD_DR : SH_DR;
            UPD_DR: tap_st = tms ? SEL_DR : RTI;
            SEL_IR: tap_st = tms ? TLR    : CAP_IR;
            CAP_IR: tap_st = tms ? EX1_IR : SH_IR;
            SH_IR:  tap_st = tms ? EX1_IR : SH_IR;
            EX1_IR: tap_st = tms ? UPD_IR : PA_IR;
            PA_IR:  tap_st = tms ? EX2_IR : PA_IR;
            EX2_IR: tap_st = tms ? UPD_IR : SH_IR;
            default: tap_st = tms ? SEL_DR : RTI;
        endcase
    end

    always @(negedge tck) tdo <= (tap_st == SH_IR) ? ir_sh[0] : dr_sh[0];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one command and returns the accept-to-response latency and the TCK count at accept.
    task automatic applyStimulus(input logic [1:0] t, input logic [LEN_W-1:0] l, input logic [31:0] d,
                                 output int lat, output int base);
        int w = 0;
        while (!cmd_ready && w < LIMIT) begin @(posedge clk); #1; w++; end
        if (!cmd_ready) checkOutput("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_v = 1'b1; cmd_type = t; cmd_len = l; cmd_data = d;
        @(posedge clk); #1;
        cmd_v = 1'b0;
        base = tck_count;
        lat = 1;
        while (!rsp_v && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic finishResponse();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Checks a 6-pulse TAP reset sequence starting at log index base; releases rst first.
    task automatic checkResetSequence(input string tag);
        int lat = 1;
        int base;
        logic [5:0] seq;
        rst = 1'b0;
        base = tck_count;
        while (!cmd_ready && lat < LIMIT) begin @(posedge clk); #1; lat++; end
        checkOutput({tag, "_ready_lat"}, 32'(lat), 32'd25);
        checkOutput({tag, "_pulses"}, 32'(tck_count - base), 32'd6);
        for (int i = 0; i < 6; i++) seq[i] = log_tms[base + i];
        checkOutput({tag, "_tms_seq"}, 32'(seq), 32'b011111);
        checkOutput({tag, "_tap_rti"}, 32'(tap_st), 32'(RTI));
        checkOutput({tag, "_tms_idle"}, 32'(tms), 32'd0);
        checkOutput({tag, "_tck_idle"}, 32'(tck), 32'd0);
    endtask

    initial begin
        int lat, base, w, n;
        logic [2:0] ir_tdi, ir_tms;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_outputs", {25'h0, tck, tms, tdi, cmd_ready, rsp_v, rsp_err, 1'b0}, 32'h20);
        checkOutput("rst_data", rsp_data, 32'h0);
        checkResetSequence("init");

        applyStimulus(2'b10, 6'd32, 32'h0, lat, base);
        checkOutput("idcode_lat", 32'(lat), 32'd149);
        checkOutput("idcode_data", rsp_data, IDCODE);
        checkOutput("idcode_err", 32'(rsp_err), 32'd0);
        finishResponse();

        applyStimulus(2'b01, 6'd0, 32'h5, lat, base);
        checkOutput("ir_lat", 32'(lat), 32'd37);
        checkOutput("ir_data", rsp_data, 32'h1);
        checkOutput("ir_err", 32'(rsp_err), 32'd0);
        n = 0; ir_tdi = '0; ir_tms = '0;
        for (int i = base; i < tck_count; i++) begin
            if (log_st[i] == SH_IR && n < 3) begin
                ir_tdi[n] = log_tdi[i];
                ir_tms[n] = log_tms[i];
                n++;
            end
        end
        checkOutput("ir_shift_bits", 32'(n), 32'd3);
        checkOutput("ir_tdi_seq", 32'(ir_tdi), 32'b101);
        checkOutput("ir_tms_seq", 32'(ir_tms), 32'b100);
        checkOutput("ir_tap_rti", 32'(tap_st), 32'(RTI));
        finishResponse();

        applyStimulus(2'b10, 6'd8, 32'hA5, lat, base);
        checkOutput("bypass_lat", 32'(lat), 32'd53);
        checkOutput("bypass_data", rsp_data, 32'h4A);
        finishResponse();

        applyStimulus(2'b00, 6'd0, 32'hFFFF_FFFF, lat, base);
        checkOutput("reset_lat", 32'(lat), 32'd25);
        checkOutput("reset_data", rsp_data, 32'h0);
        checkOutput("reset_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_tap_rti", 32'(tap_st), 32'(RTI));
        finishResponse();

        applyStimulus(2'b10, 6'd0, 32'h1234, lat, base);
        checkOutput("len0_lat", 32'(lat), 32'd1);
        checkOutput("len0_err", 32'(rsp_err), 32'd1);
        checkOutput("len0_data", rsp_data, 32'h0);
        checkOutput("len0_pulses", 32'(tck_count - base), 32'd0);
        finishResponse();

        applyStimulus(2'b10, 6'd33, 32'h1234, lat, base);
        checkOutput("len33_lat", 32'(lat), 32'd1);
        checkOutput("len33_err", 32'(rsp_err), 32'd1);
        checkOutput("len33_pulses", 32'(tck_count - base), 32'd0);
        finishResponse();

        applyStimulus(2'b11, 6'd4, 32'h1, lat, base);
        checkOutput("type3_lat", 32'(lat), 32'd1);
        checkOutput("type3_err", 32'(rsp_err), 32'd1);
        checkOutput("type3_pulses", 32'(tck_count - base), 32'd0);
        finishResponse();

        // Abort a DR scan during the low phase of shift bit 5.
        w = 0;
        while (!cmd_ready && w < LIMIT) begin @(posedge clk); #1; w++; end
        cmd_v = 1'b1; cmd_type = 2'b10; cmd_len = 6'd32; cmd_data = 32'h0;
        @(posedge clk); #1;
        cmd_v = 1'b0;
        base = tck_count;
        w = 0;
        while (((tck_count - base) < 8 || tck) && w < LIMIT) begin @(posedge clk); #1; w++; end
        checkOutput("midrst_in_shift", 32'(tap_st), 32'(SH_DR));
        checkOutput("midrst_tms_before", 32'(tms), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_tck", 32'(tck), 32'd0);
        checkOutput("midrst_tms", 32'(tms), 32'd1);
        checkOutput("midrst_ready", 32'(cmd_ready), 32'd0);
        checkResetSequence("midrst");

        applyStimulus(2'b10, 6'd32, 32'h0, lat, base);
        checkOutput("post_rst_idcode", rsp_data, IDCODE);

        // Hold off the response while another command is offered.
        cmd_v = 1'b1; cmd_type = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_rsp_v", 32'(rsp_v), 32'd1);
            checkOutput("stall_data", rsp_data, IDCODE);
            checkOutput("stall_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_v = 1'b0;
        rsp_ready = 1'b0;
        checkOutput("stall_rsp_done", 32'(rsp_v), 32'd0);
        checkOutput("stall_ready_after", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("stall_no_accept", 32'(cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
